// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM state type and GF(2^8) helper functions.
package aes_pkg;
  localparam int         AES_NR      = 10;
  localparam logic [7:0] AES_POLY    = 8'h1b;
  localparam logic [7:0] AES_RC_LAST = 8'h36;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_EMIT, S_FIN} ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Exact inverse of xtime: undoes the reduction when the product was odd.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ AES_POLY) >> 1) | 8'h80) : (x >> 1);
  endfunction
endpackage

// File: rtl/inv_key_schedule_if.sv
// Control/round-key bus of the inverse key schedule.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  modport master (output start, key_in, rk_ready,
                  input  rk_data, rk_round, rk_valid, busy, done);
  modport slave  (input  start, key_in, rk_ready,
                  output rk_data, rk_round, rk_valid, busy, done);
endinterface

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] sq, inv;

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the standard requires.
  always_comb begin
    sq  = a_i;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/ks_sub_rot_word.sv
// SubWord(RotWord(word)) ^ {rc,24'h0}; shared by the forward and backward steps.
module ks_sub_rot_word (
  input  logic [31:0] word_i,
  input  logic [7:0]  rc_i,
  output logic [31:0] word_o
);
  logic [31:0] rot, sub;

  assign rot = {word_i[23:0], word_i[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot[8*g +: 8]), .s_o(sub[8*g +: 8]));
  end

  assign word_o = sub ^ {rc_i, 24'h0};
endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: emits round keys 10..0, one per handshake, from one stored key.
// Build option INV_KS_FWD_PRECOMP_EN: key_in is the cipher key and is expanded forward first.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int         NR      = AES_NR,
  parameter logic [7:0] RC_LAST = AES_RC_LAST
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_key_schedule_if.slave  ks
);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_t    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rc_q, rc_d;

  logic [31:0] w0, w1, w2, w3, b1, b2, b3, sub_in, sr;

  assign {w0, w1, w2, w3} = key_q;
  // Backward step: the stored key is {w4..w7}; recover w1..w3 by XOR, then w0 via SubRot.
  assign b3 = w3 ^ w2;
  assign b2 = w2 ^ w1;
  assign b1 = w1 ^ w0;

`ifdef INV_KS_FWD_PRECOMP_EN
  logic [31:0] f0, f1, f2, f3;
  assign sub_in = (state_q == S_FWD) ? w3 : b3;
  assign f0 = w0 ^ sr;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
`else
  assign sub_in = b3;
`endif

  ks_sub_rot_word u_srw (.word_i(sub_in), .rc_i(rc_q), .word_o(sr));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rc_d    = rc_q;
    case (state_q)
      S_IDLE: if (ks.start) begin
        key_d = ks.key_in;
`ifdef INV_KS_FWD_PRECOMP_EN
        state_d = S_FWD;
        round_d = 4'd0;
        rc_d    = 8'h01;
`else
        state_d = S_EMIT;
        round_d = LAST_ROUND;
        rc_d    = RC_LAST;
`endif
      end
`ifdef INV_KS_FWD_PRECOMP_EN
      S_FWD: begin
        key_d   = {f0, f1, f2, f3};
        rc_d    = xtime(rc_q);
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND - 4'd1) begin
          state_d = S_EMIT;
          round_d = LAST_ROUND;
          rc_d    = RC_LAST;
        end
      end
`endif
      S_EMIT: if (ks.rk_ready) begin
        if (round_q != 4'd0) begin
          key_d   = {w0 ^ sr, b1, b2, b3};
          round_d = round_q - 4'd1;
          rc_d    = inv_xtime(rc_q);
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      rc_q    <= RC_LAST;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rc_q    <= rc_d;
    end
  end

  assign ks.rk_data  = key_q;
  assign ks.rk_round = round_q;
  assign ks.rk_valid = (state_q == S_EMIT);
  assign ks.busy     = (state_q != S_IDLE);
  assign ks.done     = (state_q == S_FIN);
endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: table-driven FIPS-197 key-expansion model, randomized backpressure.
module tb_inv_key_schedule;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_key_schedule_if bus ();
  inv_key_schedule dut (.clk(clk), .rst_n(rst_n), .ks(bus));

`ifdef INV_KS_FWD_PRECOMP_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 1;
`endif

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int errors = 0, checks = 0;
  int hs_cnt = 0, nexp = 10;
  logic done_due = 1'b0;
  logic [127:0] exp_rk [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36; default: return 8'h00;
    endcase
  endfunction

  // FIPS-197 word array w[0..43], filled backwards from the last four words.
  task automatic fill_model(input logic [127:0] k10);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[40], w[41], w[42], w[43]} = k10;
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rcon(i/4), 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Every emitted key must be the next one in the 10..0 sequence; done only after round 0.
  always @(negedge clk) begin
    if (!rst_n) begin
      nexp     = 10;
      done_due = 1'b0;
    end else begin
      chk("done", bus.done, done_due);
      if (done_due) chk("valid_in_fin", bus.rk_valid, 1'b0);
      done_due = 1'b0;
      if (bus.rk_valid) begin
        chk("rk_round", bus.rk_round, nexp);
        chk("rk_data", bus.rk_data, exp_rk[nexp]);
        chk("busy_emit", bus.busy, 1'b1);
        if (bus.rk_ready) begin
          hs_cnt++;
          if (nexp == 0) begin
            done_due = 1'b1;
            nexp     = 10;
          end else nexp--;
        end
      end
    end
  end

  task automatic run_key(input logic [127:0] k10, input int pct, input int start_at, input int rst_at);
    int lat, cyc;
    logic poked;
    fill_model(k10);
    @(posedge clk); #1;
`ifdef INV_KS_FWD_PRECOMP_EN
    bus.key_in = exp_rk[0];
`else
    bus.key_in = k10;
`endif
    hs_cnt    = 0;
    poked     = 1'b0;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end while (!bus.rk_valid && lat < 40);
    chk("first_valid_latency", lat, LAT);
    cyc = 0;
    while (cyc < 400) begin
      if (rst_at >= 0 && bus.rk_valid && bus.rk_round == 4'(rst_at)) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.rk_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_round", bus.rk_round, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_done", bus.done, 1'b0);
        return;
      end
      if (start_at >= 0 && !poked && bus.rk_valid && bus.rk_round == 4'(start_at)) begin
        bus.start = 1'b1;
        poked     = 1'b1;
      end
      bus.rk_ready = ($urandom_range(99) < pct);
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.done) break;
    end
    chk("done_seen", bus.done, 1'b1);
    chk("handshakes", hs_cnt, 11);
    @(posedge clk); #1;
    chk("idle_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b0;
    fill_model(FIPS_K10);
    repeat (3) @(posedge clk); #1;
    chk("reset_rk_data", bus.rk_data, 128'h0);
    chk("reset_rk_round", bus.rk_round, 4'd0);
    chk("reset_rk_valid", bus.rk_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    rst_n = 1'b1;

    bus.rk_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle_ready_valid", bus.rk_valid, 1'b0);
    chk("idle_ready_busy", bus.busy, 1'b0);

    chk("model_fips_k9", exp_rk[9], FIPS_K9);
    chk("model_fips_k0", exp_rk[0], FIPS_K0);

    run_key(FIPS_K10, 100, -1, -1);
    run_key(FIPS_K10, 50, -1, -1);
    run_key(FIPS_K10, 70, 5, -1);
    run_key(FIPS_K10, 100, -1, 4);
    run_key(FIPS_K10, 100, -1, -1);
    run_key(128'h0, 80, -1, -1);
    for (int n = 0; n < 6; n++)
      run_key({$urandom, $urandom, $urandom, $urandom}, 30 + int'($urandom_range(70)), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
